// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StLaunch,
        StWaitTx
    } arb_state_e;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int unsigned idw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first set request at or above i_ptr, wrapping modulo N.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IDW = idw(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic           o_found,
    output logic [IDW-1:0] o_idx
);

    int unsigned    w_pos;
    logic [IDW-1:0] w_idx;

    // Walk the offsets downward so the smallest offset from i_ptr wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        w_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_idx = IDW'(w_pos);
            if (i_req[w_idx]) begin
                o_found = 1'b1;
                o_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N byte-stream clients share one UART TX FIFO and transmitter.
// Optional stall timeout is enabled by defining UART_ARB_TIMEOUT_EN (adds o_timeout_evt).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned MAX_MSG = 8,
`ifdef UART_ARB_TIMEOUT_EN
    parameter int unsigned TIMEOUT = 64,
`endif
    localparam int unsigned IDW    = idw(N)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N-1:0]    i_req,
    input  logic [N*DW-1:0] i_req_data,
    input  logic [N-1:0]    i_req_last,
    output logic [N-1:0]    o_ack,
    output logic            o_fifo_wr,
    output logic [DW-1:0]   o_fifo_wdata,
    input  logic            i_fifo_full,
    output logic            o_tx_start,
    input  logic            i_tx_busy,
    output logic            o_grant_valid,
`ifdef UART_ARB_TIMEOUT_EN
    output logic            o_timeout_evt,
`endif
    output logic [IDW-1:0]  o_grant_id
);

    localparam int unsigned CW = idw(MAX_MSG + 1);

    arb_state_e     r_state, w_state_d;
    logic [IDW-1:0] r_rr_ptr, w_rr_ptr_d;
    logic [IDW-1:0] r_grant_id, w_grant_id_d;
    logic           r_grant_valid, w_grant_valid_d;
    logic [CW-1:0]  r_byte_cnt, w_byte_cnt_d;
    logic           r_wait_held, w_wait_held_d;

    logic           w_found;
    logic [IDW-1:0] w_pick;
    logic           w_owner_req;
    logic           w_accept;
    logic           w_last;
    logic [IDW-1:0] w_next_ptr;
    logic [DW-1:0]  w_bytes [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_bytes
        assign w_bytes[gi] = i_req_data[gi*DW +: DW];
    end

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_owner_req = i_req[r_grant_id];
    assign w_accept    = (r_state == StXfer) && w_owner_req && !i_fifo_full;
    assign w_last      = i_req_last[r_grant_id] || (r_byte_cnt == CW'(MAX_MSG - 1));
    assign w_next_ptr  = (r_grant_id == IDW'(N - 1)) ? '0 : r_grant_id + IDW'(1);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned TW = idw(TIMEOUT);

    logic [TW-1:0] r_stall_cnt, w_stall_cnt_d;
    logic          w_timeout;

    assign w_timeout     = (r_state == StXfer) && !w_owner_req &&
                           (r_stall_cnt == TW'(TIMEOUT - 1));
    assign o_timeout_evt = w_timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= w_stall_cnt_d;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_byte_cnt    <= '0;
            r_wait_held   <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_rr_ptr      <= w_rr_ptr_d;
            r_grant_id    <= w_grant_id_d;
            r_grant_valid <= w_grant_valid_d;
            r_byte_cnt    <= w_byte_cnt_d;
            r_wait_held   <= w_wait_held_d;
        end
    end

    always_comb begin
        w_state_d       = r_state;
        w_rr_ptr_d      = r_rr_ptr;
        w_grant_id_d    = r_grant_id;
        w_grant_valid_d = r_grant_valid;
        w_byte_cnt_d    = r_byte_cnt;
        w_wait_held_d   = r_wait_held;
        o_ack           = '0;
        o_fifo_wr       = 1'b0;
        o_fifo_wdata    = '0;
        o_tx_start      = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        w_stall_cnt_d   = r_stall_cnt;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_grant_id_d    = w_pick;
                    w_grant_valid_d = 1'b1;
                    w_state_d       = StXfer;
                end
            end
            StXfer: begin
                if (w_accept) begin
                    o_fifo_wr           = 1'b1;
                    o_fifo_wdata        = w_bytes[r_grant_id];
                    o_ack[r_grant_id]   = 1'b1;
                    w_byte_cnt_d        = r_byte_cnt + CW'(1);
                    if (w_last) begin
                        w_state_d = StLaunch;
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                // Only an absent owner counts as a stall; a full FIFO does not.
                if (w_accept) begin
                    w_stall_cnt_d = '0;
                end else if (!w_owner_req) begin
                    if (w_timeout) begin
                        w_stall_cnt_d = '0;
                        if (r_byte_cnt != '0) begin
                            w_state_d = StLaunch;
                        end else begin
                            w_rr_ptr_d      = w_next_ptr;
                            w_grant_valid_d = 1'b0;
                            w_state_d       = StIdle;
                        end
                    end else begin
                        w_stall_cnt_d = r_stall_cnt + TW'(1);
                    end
                end
`endif
            end
            StLaunch: begin
                o_tx_start    = 1'b1;
                w_byte_cnt_d  = '0;
                w_wait_held_d = 1'b0;
                w_state_d     = StWaitTx;
            end
            StWaitTx: begin
                // First cycle gives the transmitter time to raise tx_busy.
                if (!r_wait_held) begin
                    w_wait_held_d = 1'b1;
                end else if (!i_tx_busy) begin
                    w_rr_ptr_d      = w_next_ptr;
                    w_grant_valid_d = 1'b0;
                    w_state_d       = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign o_grant_valid = r_grant_valid;
    assign o_grant_id    = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N=4, DW=8, MAX_MSG=8).
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  req_last = '0;
    logic          fifo_full = 1'b0;
    logic [N-1:0]  ack;
    logic          fifo_wr;
    logic [DW-1:0] fifo_wdata;
    logic          tx_start;
    logic          tx_busy;
    logic          grant_valid;
    logic [1:0]    grant_id;
`ifdef UART_ARB_TIMEOUT_EN
    logic          timeout_evt;
`endif

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N       (N),
        .DW      (DW),
        .MAX_MSG (8)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .i_req_data    (req_data),
        .i_req_last    (req_last),
        .o_ack         (ack),
        .o_fifo_wr     (fifo_wr),
        .o_fifo_wdata  (fifo_wdata),
        .i_fifo_full   (fifo_full),
        .o_tx_start    (tx_start),
        .i_tx_busy     (tx_busy),
        .o_grant_valid (grant_valid),
`ifdef UART_ARB_TIMEOUT_EN
        .o_timeout_evt (timeout_evt),
`endif
        .o_grant_id    (grant_id)
    );

    // Transmitter model: busy for 4 cycles after each start pulse.
    int busy_cnt = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_cnt <= 0;
        else if (tx_start) busy_cnt <= 4;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] wr_q[$];
    int         wr_cyc_q[$];
    int         start_cyc_q[$];
    int         start_at_q[$];
    int         grant_q[$];
    int         ack_cnt[N] = '{default: 0};
    int         viol_full = 0, viol_ack = 0, viol_excl = 0, viol_busy = 0;
    logic       gv_prev = 1'b0;

    always @(negedge clk) begin
        if (fifo_wr) begin
            wr_q.push_back(fifo_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (tx_start) begin
            start_cyc_q.push_back(cyc);
            start_at_q.push_back(wr_q.size());
        end
        if (fifo_full && (fifo_wr || ack != '0)) viol_full <= viol_full + 1;
        if (ack != (fifo_wr ? (4'b0001 << grant_id) : 4'b0000)) viol_ack <= viol_ack + 1;
        if (fifo_wr && tx_start) viol_excl <= viol_excl + 1;
        if (grant_valid && !gv_prev) begin
            grant_q.push_back(int'(grant_id));
            if (tx_busy) viol_busy <= viol_busy + 1;
        end
        gv_prev <= grant_valid;
        for (int i = 0; i < N; i++) ack_cnt[i] <= ack_cnt[i] + (ack[i] ? 1 : 0);
    end

    function automatic int wr_at(input int i);
        if (i >= 0 && i < wr_q.size()) return int'(wr_q[i]);
        return -1;
    endfunction
    function automatic int wcyc_at(input int i);
        if (i >= 0 && i < wr_cyc_q.size()) return wr_cyc_q[i];
        return -1000;
    endfunction
    function automatic int scyc_at(input int i);
        if (i >= 0 && i < start_cyc_q.size()) return start_cyc_q[i];
        return -1000;
    endfunction
    function automatic int sat_at(input int i);
        if (i >= 0 && i < start_at_q.size()) return start_at_q[i];
        return -1000;
    endfunction
    function automatic int gr_at(input int i);
        if (i >= 0 && i < grant_q.size()) return grant_q[i];
        return -1;
    endfunction

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    logic [7:0] msgs [N][16];

    // Requester model: present each byte and hold it until acknowledged.
    task automatic send_msg(input int id, input int base, input int n, input bit use_last);
        bit got;
        for (int i = 0; i < n; i++) begin
            req[id] = 1'b1;
            req_data[id*DW +: DW] = msgs[id][base+i];
            req_last[id] = use_last && (i == n - 1);
            got = 1'b0;
            for (int k = 0; k < 200 && !got; k++) begin
                @(negedge clk);
                got = ack[id];
            end
            check($sformatf("ack_wait_r%0d_b%0d", id, i), {31'b0, got}, 32'd1);
            @(posedge clk);
            #1;
        end
        req[id] = 1'b0;
        req_last[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            done = !grant_valid && !tx_busy && (req == '0);
        end
        check("idle_wait", {31'b0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        req_last = '0;
        fifo_full = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int  b, sb, gb, ab, stall;
    bit  seen;

    initial begin
        msgs[2][0] = 8'h05; msgs[2][1] = 8'h06;
        msgs[0][0] = 8'h10; msgs[0][1] = 8'h14;
        msgs[1][0] = 8'h11; msgs[2][2] = 8'h12; msgs[3][8] = 8'h13;
        msgs[1][1] = 8'h21; msgs[1][2] = 8'hAA; msgs[1][3] = 8'h23;
        for (int i = 0; i < 10; i++) msgs[3][i] = 8'h30 + 8'(i);
        for (int i = 0; i < 5; i++) msgs[0][8+i] = 8'h51 + 8'(i);
        msgs[2][4] = 8'h61; msgs[2][5] = 8'h62; msgs[2][6] = 8'h63; msgs[3][10] = 8'h64;

        // Reset state
        #2;
        check("rst_fifo_wr", {31'b0, fifo_wr}, 0);
        check("rst_ack", {28'b0, ack}, 0);
        check("rst_wdata", {24'b0, fifo_wdata}, 0);
        check("rst_tx_start", {31'b0, tx_start}, 0);
        check("rst_grant_valid", {31'b0, grant_valid}, 0);
        check("rst_grant_id", {30'b0, grant_id}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: two-byte message from requester 2
        b = wr_q.size(); sb = start_cyc_q.size(); gb = grant_q.size(); ab = ack_cnt[2];
        send_msg(2, 0, 2, 1'b1);
        wait_idle();
        check("t1_wr_count", wr_q.size() - b, 2);
        check("t1_byte0", wr_at(b), 32'h05);
        check("t1_byte1", wr_at(b + 1), 32'h06);
        check("t1_ack2_count", ack_cnt[2] - ab, 2);
        check("t1_byte_gap", wcyc_at(b + 1) - wcyc_at(b), 1);
        check("t1_start_count", start_cyc_q.size() - sb, 1);
        check("t1_start_delay", scyc_at(sb) - wcyc_at(b + 1), 1);
        check("t1_grant", gr_at(gb), 2);

        // 2: all four requesting, round-robin from 0
        do_reset();
        b = wr_q.size(); sb = start_cyc_q.size(); gb = grant_q.size();
        fork
            begin send_msg(0, 0, 1, 1'b1); send_msg(0, 1, 1, 1'b1); end
            send_msg(1, 0, 1, 1'b1);
            send_msg(2, 2, 1, 1'b1);
            send_msg(3, 8, 1, 1'b1);
        join
        wait_idle();
        check("t2_grant0", gr_at(gb), 0);
        check("t2_grant1", gr_at(gb + 1), 1);
        check("t2_grant2", gr_at(gb + 2), 2);
        check("t2_grant3", gr_at(gb + 3), 3);
        check("t2_grant4", gr_at(gb + 4), 0);
        check("t2_wr_count", wr_q.size() - b, 5);
        check("t2_byte4", wr_at(b + 4), 32'h14);
        check("t2_start_count", start_cyc_q.size() - sb, 5);

        // 3: FIFO full for 5 cycles mid-message
        do_reset();
        b = wr_q.size(); ab = ack_cnt[1];
        fork
            send_msg(1, 1, 3, 1'b1);
            begin
                seen = 1'b0;
                for (int k = 0; k < 100 && !seen; k++) begin
                    @(negedge clk);
                    #1 seen = (wr_q.size() > b);
                end
                @(posedge clk);
                #1 fifo_full = 1'b1;
                repeat (5) @(posedge clk);
                #1 fifo_full = 1'b0;
            end
        join
        wait_idle();
        check("t3_wr_count", wr_q.size() - b, 3);
        check("t3_byte0", wr_at(b), 32'h21);
        check("t3_byte1", wr_at(b + 1), 32'hAA);
        check("t3_byte2", wr_at(b + 2), 32'h23);
        check("t3_ack1_count", ack_cnt[1] - ab, 3);
        check("t3_stall_gap", wcyc_at(b + 1) - wcyc_at(b), 6);

        // 4: 10 bytes, cut at MAX_MSG=8
        do_reset();
        b = wr_q.size(); sb = start_cyc_q.size(); gb = grant_q.size();
        send_msg(3, 0, 10, 1'b1);
        wait_idle();
        check("t4_wr_count", wr_q.size() - b, 10);
        for (int i = 0; i < 10; i++) check($sformatf("t4_byte%0d", i), wr_at(b + i), 32'h30 + i);
        check("t4_start_count", start_cyc_q.size() - sb, 2);
        check("t4_first_cut", sat_at(sb) - b, 8);
        check("t4_second_cut", sat_at(sb + 1) - b, 10);
        check("t4_grant_count", grant_q.size() - gb, 2);
        check("t4_regrant_id", gr_at(gb + 1), 3);

        // 5: reset asserted in XFER after 3 bytes
        do_reset();
        b = wr_q.size(); sb = start_cyc_q.size(); gb = grant_q.size();
        fork
            send_msg(0, 8, 5, 1'b1);
            begin
                seen = 1'b0;
                for (int k = 0; k < 100 && !seen; k++) begin
                    @(negedge clk);
                    #1 seen = (wr_q.size() >= b + 3);
                end
                @(posedge clk);
                #3 rst_n = 1'b0;
                #1;
                check("t5_fifo_wr", {31'b0, fifo_wr}, 0);
                check("t5_ack", {28'b0, ack}, 0);
                check("t5_wdata", {24'b0, fifo_wdata}, 0);
                check("t5_tx_start", {31'b0, tx_start}, 0);
                check("t5_grant_valid", {31'b0, grant_valid}, 0);
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        wait_idle();
        check("t5_wr_count", wr_q.size() - b, 5);
        for (int i = 0; i < 5; i++) check($sformatf("t5_byte%0d", i), wr_at(b + i), 32'h51 + i);
        check("t5_start_count", start_cyc_q.size() - sb, 1);
        check("t5_start_at", sat_at(sb) - b, 5);
        check("t5_regrant", gr_at(gb + 1), 0);

`ifdef UART_ARB_TIMEOUT_EN
        // 6: owner stalls after 2 bytes
        do_reset();
        b = wr_q.size(); sb = start_cyc_q.size(); gb = grant_q.size();
        send_msg(2, 4, 2, 1'b0);
        stall = 0;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            stall++;
            seen = timeout_evt;
        end
        check("t6_stall_cycles", stall, 64);
        @(negedge clk);
        check("t6_start_after_evt", {31'b0, tx_start}, 1);
        @(posedge clk);
        #1;
        wait_idle();
        check("t6_wr_count", wr_q.size() - b, 2);
        check("t6_start_count", start_cyc_q.size() - sb, 1);
        fork
            send_msg(2, 6, 1, 1'b1);
            send_msg(3, 10, 1, 1'b1);
        join
        wait_idle();
        check("t6_grant0", gr_at(gb), 2);
        check("t6_grant1", gr_at(gb + 1), 3);
        check("t6_grant2", gr_at(gb + 2), 2);
`endif

        check("never_write_when_full", viol_full, 0);
        check("ack_matches_write", viol_ack, 0);
        check("write_start_exclusive", viol_excl, 0);
        check("grant_while_busy", viol_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmit FIFO and transmitter between N byte-stream requesters. Each message from a requester is written to the FIFO as one contiguous run of bytes. A single start pulse then launches transmission of the whole run. The block waits for the transmitter to go idle before granting the next requester, using round-robin fairness. It sits between the client logic and the write/start ports of the UART TX FIFO.

Parameters:
N, 4, number of requesters (2..8)
DW, 8, data byte width
MAX_MSG, 8, maximum bytes per grant; must not exceed FIFO depth
TIMEOUT, 64, stall cycles before abort (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  N  per-requester byte valid
req_data  in  N*DW  packed bytes; requester i uses bits [i*DW +: DW]
req_last  in  N  current byte is the last of the message
ack  out  N  one-cycle pulse: byte of requester i accepted this cycle
fifo_wr  out  1  write strobe to the TX FIFO
fifo_wdata  out  DW  byte to the TX FIFO
fifo_full  in  1  TX FIFO full
tx_start  out  1  one-cycle start pulse to the transmitter
tx_busy  in  1  transmitter shifting or FIFO non-empty
grant_valid  out  1  a requester currently owns the channel
grant_id  out  $clog2(N)  index of the owner

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE, rr_ptr=0, byte_cnt=0. All outputs are 0: ack, fifo_wr, fifo_wdata, tx_start, grant_valid, grant_id.
- States: IDLE, XFER, LAUNCH, WAIT_TX.
- IDLE:
  - If any req bit is high, pick the first set bit searching from rr_ptr upward, wrapping modulo N.
  - Register it as grant_id, set grant_valid=1, go to XFER next cycle.
  - Selection costs 1 cycle of latency, so no byte is accepted in IDLE.
- XFER:
  - Byte accept condition: req[grant_id] & ~fifo_full.
  - On accept: fifo_wr=1, fifo_wdata=req byte, ack[grant_id]=1, all in the same cycle (combinational from registered grant). byte_cnt increments.
  - Go to LAUNCH if req_last is set or byte_cnt reaches MAX_MSG-1 on the accepted byte. Otherwise stay in XFER.
  - fifo_full high: no write, no ack; the requester holds its byte.
  - Requests from non-granted requesters are ignored; their ack stays 0.
- LAUNCH: tx_start=1 for exactly one cycle. Clear byte_cnt. Go to WAIT_TX.
- WAIT_TX:
  - Hold for at least 2 cycles, so the transmitter can raise tx_busy.
  - Then leave when tx_busy=0: rr_ptr=(grant_id+1) mod N, grant_valid=0, go to IDLE.
- Only one of fifo_wr and tx_start is ever high in a given cycle.
- Message cut by MAX_MSG: the requester keeps req high and is re-arbitrated normally. Its next bytes form a new message.
- Simultaneous requests in IDLE: round-robin only. No requester is granted twice while another has been waiting through a full rotation.
- Reset mid-operation: abort immediately; no start pulse is issued. Bytes already written stay in the FIFO; the FIFO's own reset handles them.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined: a stall counter runs in XFER while req[grant_id]=0. On reaching TIMEOUT, if byte_cnt>0 go to LAUNCH (sends the partial message); if byte_cnt=0 go directly to IDLE and advance rr_ptr. Any accepted byte clears the counter. Adds output timeout_evt (1 bit, one-cycle pulse on abort).
- Not defined: XFER waits indefinitely for the owner. There is no counter and no timeout_evt port.

Decomposition:
- Shared package uart_arb_pkg holds the state enum (IDLE, XFER, LAUNCH, WAIT_TX) and the localparam IDW=$clog2(N) helper.
- One sub-module, rr_pick: combinational round-robin priority encoder. Inputs: req vector and rr_ptr. Outputs: found and index.

Test Plan:
1. req[2]=1, bytes 0x05,0x06, req_last on 0x06 -> fifo_wdata 0x05 then 0x06 on consecutive cycles. ack[2] pulses twice. tx_start pulses once, 1 cycle after the 0x06 write.
2. req=4'b1111 held, 1-byte messages each, rr_ptr=0 -> grant order 0,1,2,3,0. Each new grant waits for tx_busy to fall.
3. fifo_full=1 for 5 cycles mid-message -> no fifo_wr or ack during the stall. Resumes with the held byte 0xAA; no byte lost or duplicated.
4. MAX_MSG=8, requester sends 10 bytes with no req_last -> tx_start after byte 8. Channel re-arbitrated; remaining 2 bytes sent under a second grant.
5. reset pulled low in XFER after 3 bytes -> all outputs 0 asynchronously, state IDLE, no tx_start. After reset is released the next request is granted normally.
6. (UART_ARB_TIMEOUT_EN, TIMEOUT=64) owner sends 2 bytes then drops req -> after 64 cycles timeout_evt pulses and tx_start pulses. rr_ptr advances.
